sparse_expand: RTL

- Decompression counterpart of the post-sparsity stage. Consumes a sparsity mask of `length` bits and a compacted stream of nonzero values, 16 values per beat.
- Rebuilds the dense activation vector and emits it as 16-lane chunks of IL+FL fixed-point values, with zeros at masked-off positions.
- Sits between the sparse activation buffer and the dense MAC lanes. Uses the codebase's `input_ready` / `output_taken` / `state` handshake.

---
 rtl/sparse_expand.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sparse_expand.sv
// sparse_expand: rebuilds a dense fixed-point vector from a sparsity mask and a
// compacted stream of nonzero values, emitting it as 16-lane chunks.
module sparse_expand #(
    parameter int IL       = 4,
    parameter int FL       = 16,
    parameter int length   = 32,
    parameter int p_length = $clog2(length)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [length-1:0]        i_mask,
    input  logic [15:0][IL+FL-1:0]   i_vals,
    input  logic                     input_ready,
    input  logic                     i_val_valid,
    output logic                     o_val_req,
    input  logic                     output_taken,
    output logic [15:0][IL+FL-1:0]   o_im,
    output logic                     o_last,
    output logic [1:0]               state
);
    localparam int W = IL + FL;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXPAND = 2'b01,
        DONE   = 2'b10,
        FETCH  = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic [length-1:0]     mask_q, mask_d;
    logic [15:0][W-1:0]    vbuf_q, vbuf_d;
    logic [15:0][W-1:0]    o_im_q, o_im_d;
    logic [3:0]            rd_ptr_q, rd_ptr_d;
    logic                  empty_q, empty_d;
    logic                  o_last_q, o_last_d;
    logic [p_length-1:0]   pos_q, pos_d;
    logic [p_length-1:0]   pos_inc;
    logic [3:0]            lane;
    logic                  last_pos;

    assign lane     = pos_q[3:0];
    assign last_pos = (pos_q == p_length'(length - 1));
    assign pos_inc  = last_pos ? '0 : pos_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        vbuf_d   = vbuf_q;
        o_im_d   = o_im_q;
        rd_ptr_d = rd_ptr_q;
        empty_d  = empty_q;
        o_last_d = o_last_q;
        pos_d    = pos_q;
        case (state_q)
            IDLE: begin
                if (input_ready) begin
                    mask_d   = i_mask;
                    vbuf_d   = i_vals;
                    rd_ptr_d = '0;
                    empty_d  = 1'b0;
                    pos_d    = '0;
                    state_d  = EXPAND;
                end
            end
            EXPAND: begin
                // A set mask bit with a drained buffer stalls this position until a beat arrives
                if (mask_q[pos_q] && empty_q) begin
                    state_d = FETCH;
                end else begin
                    o_im_d[lane] = mask_q[pos_q] ? vbuf_q[rd_ptr_q] : '0;
                    if (mask_q[pos_q]) begin
                        rd_ptr_d = rd_ptr_q + 4'd1;
                        empty_d  = (rd_ptr_q == 4'd15);
                    end
                    pos_d = pos_inc;
                    if (lane == 4'd15) begin
                        state_d  = DONE;
                        o_last_d = last_pos;
                    end
                end
            end
            DONE: begin
                if (output_taken) state_d = o_last_q ? IDLE : EXPAND;
            end
            FETCH: begin
                if (i_val_valid) begin
                    vbuf_d   = i_vals;
                    rd_ptr_d = '0;
                    empty_d  = 1'b0;
                    state_d  = EXPAND;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            vbuf_q   <= '0;
            o_im_q   <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b0;
            o_last_q <= 1'b0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            vbuf_q   <= vbuf_d;
            o_im_q   <= o_im_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            o_last_q <= o_last_d;
            pos_q    <= pos_d;
        end
    end

    assign state     = state_q;
    assign o_im      = o_im_q;
    assign o_last    = o_last_q;
    assign o_val_req = (state_q == FETCH);
endmodule
